reg_scoreboard: RTL and testbench

//  Per-register in-flight write tracker for the 5-stage pipeline. Sits beside the register file.

---
 rtl/reg_scoreboard_pkg.sv | 23 ++
 rtl/reg_scoreboard_scb_counter.sv | 52 +++++
 rtl/reg_scoreboard.sv | 120 ++++++++++++
 tb/tb_reg_scoreboard.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard: register addressing, control
// constants, the per-register counter type and a tracked-register predicate.
// Imported by reg_scoreboard and scb_counter.
package reg_scoreboard_pkg;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned RegNum     = 32;
    typedef logic [REG_ADDR_W-1:0] RegAddrBus;

    localparam logic [6:0] OpcodeLoad = 7'b0000011;

    localparam int unsigned SCB_CNT_W = 2;
    typedef logic [SCB_CNT_W-1:0] ScbCntBus;

    // x0 is hardwired to zero, so it never has a producer worth waiting for.
    function automatic logic is_tracked(input RegAddrBus addr);
        return (addr != '0) ? Enable : Disable;
    endfunction

endpackage

// File: rtl/reg_scoreboard_scb_counter.sv
// Saturating CNT_W-bit up/down counter used for per-register writer/load counts.
// Latency: count updates at the next clk edge; ovf_o is a same-cycle pulse.
// Backpressure: none; simultaneous inc and dec cancel.
// Ports: clk, rst (async active-high), inc_i, dec_i, cnt_o (current count),
//        ovf_o (pulse: inc at max or dec at zero, count held).
module scb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W = SCB_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_o = Disable;
        if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) begin
                ovf_o = Enable;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) begin
                ovf_o = Enable;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register in-flight writer/load tracker; raises the load-use stall request.
// Latency: stallreq_o is combinational from the read ports; counters, busy_o,
//          ovf_o and stall_cnt_o reflect events from the next clk edge.
// Backpressure: none consumed; stallreq_o is the backpressure it produces.
// Ports: issue_* (ID->EX issue), ldone_* (load data in MEM), wb_* (write-back),
//        re/raddr 1,2 (ID reads), stallreq_o, busy_o, ovf_o (sticky), stall_cnt_o.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS    = RegNum,
    parameter int unsigned CNT_W       = SCB_CNT_W,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_i,
    input  logic                   issue_we_i,
    input  RegAddrBus              issue_rd_i,
    input  logic                   issue_load_i,
    input  logic                   ldone_i,
    input  RegAddrBus              ldone_rd_i,
    input  logic                   wb_we_i,
    input  RegAddrBus              wb_waddr_i,
    input  logic                   re1_i,
    input  RegAddrBus              raddr1_i,
    input  logic                   re2_i,
    input  RegAddrBus              raddr2_i,
    output logic                   stallreq_o,
    output logic                   busy_o,
    output logic                   ovf_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

    // Per-register summary vectors; bit 0 (x0) is constant zero.
    logic [NUM_REGS-1:0] w_nz;    // writer count nonzero
    logic [NUM_REGS-1:0] l_pend;  // load still outstanding after the MEM bypass
    logic [NUM_REGS-1:0] w_ovf;
    logic [NUM_REGS-1:0] l_ovf;

    assign w_nz[0]   = Disable;
    assign l_pend[0] = Disable;
    assign w_ovf[0]  = Disable;
    assign l_ovf[0]  = Disable;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic             w_inc;
        logic             w_dec;
        logic             l_inc;
        logic             l_dec;
        logic [CNT_W-1:0] wcnt;
        logic [CNT_W-1:0] lcnt;

        assign w_inc = issue_i & issue_we_i & (issue_rd_i == REG_ADDR_W'(r));
        assign w_dec = wb_we_i & (wb_waddr_i == REG_ADDR_W'(r));
        assign l_inc = w_inc & issue_load_i;
        assign l_dec = ldone_i & (ldone_rd_i == REG_ADDR_W'(r));

        scb_counter #(.CNT_W(CNT_W)) u_wcnt (
            .clk   (clk),
            .rst   (rst),
            .inc_i (w_inc),
            .dec_i (w_dec),
            .cnt_o (wcnt),
            .ovf_o (w_ovf[r])
        );

        scb_counter #(.CNT_W(CNT_W)) u_lcnt (
            .clk   (clk),
            .rst   (rst),
            .inc_i (l_inc),
            .dec_i (l_dec),
            .cnt_o (lcnt),
            .ovf_o (l_ovf[r])
        );

        assign w_nz[r] = |wcnt;
        // A load completing this cycle is forwarded from MEM, so it no longer
        // counts as pending; only one more outstanding load keeps the stall.
        assign l_pend[r] = l_dec ? (lcnt > CNT_W'(1)) : (lcnt != '0);
    end

    logic src1_stall;
    logic src2_stall;

    assign src1_stall = re1_i & is_tracked(raddr1_i) & l_pend[raddr1_i];
    assign src2_stall = re2_i & is_tracked(raddr2_i) & l_pend[raddr2_i];
    assign stallreq_o = src1_stall | src2_stall;

    // Counter state is registered, so this OR is a function of flops only.
    assign busy_o = |w_nz;

    logic                   ovf_q;
    logic                   ovf_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    always_comb begin
        ovf_d       = ovf_q | (|w_ovf) | (|l_ovf);
        stall_cnt_d = stall_cnt_q;
        if (stallreq_o && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q       <= Disable;
            stall_cnt_q <= '0;
        end else begin
            ovf_q       <= ovf_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ovf_o       = ovf_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: the driver applies one stimulus vector per
// cycle and queues the expected outputs from a count-per-register reference model;
// a monitor pops and compares on every falling edge.
module tb_reg_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_i, issue_we_i, issue_load_i;
    logic [4:0]  issue_rd_i;
    logic        ldone_i;
    logic [4:0]  ldone_rd_i;
    logic        wb_we_i;
    logic [4:0]  wb_waddr_i;
    logic        re1_i, re2_i;
    logic [4:0]  raddr1_i, raddr2_i;
    logic        stallreq_o, busy_o, ovf_o;
    logic [31:0] stall_cnt_o;

    reg_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issue_i      (issue_i),
        .issue_we_i   (issue_we_i),
        .issue_rd_i   (issue_rd_i),
        .issue_load_i (issue_load_i),
        .ldone_i      (ldone_i),
        .ldone_rd_i   (ldone_rd_i),
        .wb_we_i      (wb_we_i),
        .wb_waddr_i   (wb_waddr_i),
        .re1_i        (re1_i),
        .raddr1_i     (raddr1_i),
        .re2_i        (re2_i),
        .raddr2_i     (raddr2_i),
        .stallreq_o   (stallreq_o),
        .busy_o       (busy_o),
        .ovf_o        (ovf_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       issue, we, load;
        bit [4:0] rd;
        bit       ldone;
        bit [4:0] ldrd;
        bit       wb;
        bit [4:0] waddr;
        bit       re1, re2;
        bit [4:0] ra1, ra2;
    } stim_t;

    typedef struct {
        bit        stall, busy, ovf;
        bit [31:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: plain integer counts per register.
    int        m_w[32];
    int        m_l[32];
    bit        m_ovf;
    bit [31:0] m_scnt;

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            m_w[r] = 0;
            m_l[r] = 0;
        end
        m_ovf  = 0;
        m_scnt = 0;
    endfunction

    function automatic int clamp_step(int v, int d);
        int n;
        n = v + d;
        if (n > 3) begin m_ovf = 1; return 3; end
        if (n < 0) begin m_ovf = 1; return 0; end
        return n;
    endfunction

    function automatic bit pending(stim_t s, bit en, bit [4:0] a);
        int eff;
        if (!en || a == 0) return 0;
        eff = m_l[a] - ((s.ldone && s.ldrd == a) ? 1 : 0);
        return eff > 0;
    endfunction

    function automatic exp_t expect_now(stim_t s);
        exp_t e;
        e.stall = pending(s, s.re1, s.ra1) || pending(s, s.re2, s.ra2);
        e.busy  = 0;
        for (int r = 0; r < 32; r++) if (m_w[r] != 0) e.busy = 1;
        e.ovf   = m_ovf;
        e.scnt  = m_scnt;
        return e;
    endfunction

    function automatic void model_clock(stim_t s, bit stall);
        int dw, dl;
        if (s.rst) begin
            model_reset();
            return;
        end
        if (stall && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
        for (int r = 1; r < 32; r++) begin
            dw = ((s.issue && s.we && s.rd == r) ? 1 : 0) - ((s.wb && s.waddr == r) ? 1 : 0);
            dl = ((s.issue && s.we && s.load && s.rd == r) ? 1 : 0)
               - ((s.ldone && s.ldrd == r) ? 1 : 0);
            if (dw != 0) m_w[r] = clamp_step(m_w[r], dw);
            if (dl != 0) m_l[r] = clamp_step(m_l[r], dl);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    // Called just after a rising edge: drive, queue expectation, clock the model.
    task automatic step(input stim_t s);
        exp_t e;
        rst          = s.rst;
        issue_i      = s.issue;
        issue_we_i   = s.we;
        issue_load_i = s.load;
        issue_rd_i   = s.rd;
        ldone_i      = s.ldone;
        ldone_rd_i   = s.ldrd;
        wb_we_i      = s.wb;
        wb_waddr_i   = s.waddr;
        re1_i        = s.re1;
        raddr1_i     = s.ra1;
        re2_i        = s.re2;
        raddr2_i     = s.ra2;
        if (s.rst) model_reset();
        e = expect_now(s);
        exp_q.push_back(e);
        @(posedge clk);
        model_clock(s, e.stall);
        #1;
    endtask

    task automatic issue_op(input bit [4:0] rd, input bit load);
        stim_t s;
        s = idle(); s.issue = 1; s.we = 1; s.rd = rd; s.load = load;
        step(s);
    endtask

    task automatic read_regs(input bit en1, input bit [4:0] a1, input bit en2,
                             input bit [4:0] a2, input bit ld, input bit [4:0] ldrd);
        stim_t s;
        s = idle(); s.re1 = en1; s.ra1 = a1; s.re2 = en2; s.ra2 = a2;
        s.ldone = ld; s.ldrd = ldrd;
        step(s);
    endtask

    task automatic wb_reg(input bit [4:0] a);
        stim_t s;
        s = idle(); s.wb = 1; s.waddr = a;
        step(s);
    endtask

    task automatic do_reset();
        stim_t s;
        s = idle(); s.rst = 1;
        step(s);
    endtask

    // Monitor: the DUT presents a full output vector every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks += 4;
                if (stallreq_o !== e.stall) begin
                    n_fail++;
                    $display("FAIL stallreq t=%0t got=%b exp=%b", $time, stallreq_o, e.stall);
                end
                if (busy_o !== e.busy) begin
                    n_fail++;
                    $display("FAIL busy t=%0t got=%b exp=%b", $time, busy_o, e.busy);
                end
                if (ovf_o !== e.ovf) begin
                    n_fail++;
                    $display("FAIL ovf t=%0t got=%b exp=%b", $time, ovf_o, e.ovf);
                end
                if (stall_cnt_o !== e.scnt) begin
                    n_fail++;
                    $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt_o, e.scnt);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;
        model_reset();
        rst = 1;
        {issue_i, issue_we_i, issue_load_i, ldone_i, wb_we_i, re1_i, re2_i} = '0;
        {issue_rd_i, ldone_rd_i, wb_waddr_i, raddr1_i, raddr2_i} = '0;
        @(posedge clk); #1;
        do_reset();
        do_reset();

        // Reset mid-stall with two loads pending on x5, read held through it.
        issue_op(5'd5, 1);
        issue_op(5'd5, 1);
        read_regs(1, 5'd5, 0, 5'd0, 0, 5'd0);
        s = idle(); s.rst = 1; s.re1 = 1; s.ra1 = 5'd5;
        step(s);
        read_regs(1, 5'd5, 0, 5'd0, 0, 5'd0);

        // Load-use stall until the completion cycle.
        issue_op(5'd5, 1);
        repeat (3) read_regs(1, 5'd5, 0, 5'd0, 0, 5'd0);
        read_regs(1, 5'd5, 0, 5'd0, 1, 5'd5);
        read_regs(1, 5'd5, 0, 5'd0, 0, 5'd0);
        wb_reg(5'd5);

        // Same-cycle issue and write-back of x7.
        issue_op(5'd7, 0);
        s = idle(); s.issue = 1; s.we = 1; s.rd = 5'd7; s.wb = 1; s.waddr = 5'd7;
        step(s);
        step(idle());
        wb_reg(5'd7);
        step(idle());

        // x0 is never tracked.
        issue_op(5'd0, 1);
        read_regs(1, 5'd0, 1, 5'd0, 0, 5'd0);
        wb_reg(5'd0);
        s = idle(); s.ldone = 1; s.ldrd = 5'd0;
        step(s);
        step(idle());

        // Two sources pending, completed one at a time.
        issue_op(5'd3, 1);
        issue_op(5'd4, 1);
        read_regs(1, 5'd3, 1, 5'd4, 0, 5'd0);
        read_regs(1, 5'd3, 1, 5'd4, 1, 5'd3);
        read_regs(1, 5'd3, 1, 5'd4, 0, 5'd0);
        read_regs(1, 5'd3, 1, 5'd4, 1, 5'd4);
        read_regs(1, 5'd3, 1, 5'd4, 0, 5'd0);
        wb_reg(5'd3);
        wb_reg(5'd4);

        // Four loads to x9 saturate at three and set the sticky flag.
        repeat (4) issue_op(5'd9, 1);
        read_regs(1, 5'd9, 0, 5'd0, 0, 5'd0);
        repeat (3) read_regs(0, 5'd0, 1, 5'd9, 1, 5'd9);
        repeat (3) wb_reg(5'd9);
        step(idle());

        // Randomized traffic on a narrow register window with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst   = ($urandom_range(99) < 2);
            s.issue = ($urandom_range(99) < 50);
            s.we    = ($urandom_range(99) < 80);
            s.load  = ($urandom_range(99) < 50);
            s.rd    = 5'($urandom_range(7));
            s.ldone = ($urandom_range(99) < 30);
            s.ldrd  = 5'($urandom_range(7));
            s.wb    = ($urandom_range(99) < 40);
            s.waddr = 5'($urandom_range(7));
            s.re1   = ($urandom_range(99) < 70);
            s.ra1   = 5'($urandom_range(7));
            s.re2   = ($urandom_range(99) < 70);
            s.ra2   = 5'($urandom_range(7));
            step(s);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
